// File: rtl/sum_accumulator.sv
// Frame accumulator behind the signed two-operand adder: sums K input samples and holds
// the narrowed result on a valid/ready output. Define SUM_ACC_SAT_EN for saturation instead of wrapping.
module sum_accumulator #(
    parameter int n = 4,
    parameter int K = 4,
    parameter int m = n + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic signed [n:0]   S,
    input  logic                S_valid,
    output logic                S_ready,
    output logic signed [m-1:0] A,
    output logic                A_valid,
    input  logic                A_ready,
    output logic                OV
);

    localparam int CW = $clog2(K);
    localparam int W  = n + 1 + CW;

    typedef enum logic {
        ACC,
        HOLD
    } state_t;

    state_t              state;
    state_t              state_next;
    logic signed [W-1:0] acc;
    logic        [CW-1:0] cnt;
    logic signed [W-1:0] s_ext;
    logic signed [W-1:0] sum_full;
    logic                last;
    logic                ov_next;
    logic signed [m-1:0] a_next;

    assign s_ext    = {{CW{S[n]}}, S};
    assign sum_full = acc + s_ext;
    assign last     = (cnt == CW'(K - 1));

    // The sum fits in m bits exactly when all bits from m-1 upward agree with the sign bit.
    assign ov_next = !((&sum_full[W-1:m-1]) || (~|sum_full[W-1:m-1]));

`ifdef SUM_ACC_SAT_EN
    localparam logic [m-1:0] A_MAX = {1'b0, {(m - 1){1'b1}}};
    localparam logic [m-1:0] A_MIN = {1'b1, {(m - 1){1'b0}}};

    assign a_next = ov_next ? (sum_full[W-1] ? A_MIN : A_MAX) : sum_full[m-1:0];
`else
    assign a_next = sum_full[m-1:0];
`endif

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        S_ready    = 1'b0;
        A_valid    = 1'b0;
        case (state)
            ACC: begin
                S_ready = 1'b1;
                if (!clr && S_valid && last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                A_valid = 1'b1;
                if (A_ready) begin
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            A     <= '0;
            OV    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ACC) begin
                if (clr) begin
                    acc <= '0;
                    cnt <= '0;
                end else if (S_valid) begin
                    if (last) begin
                        A   <= a_next;
                        OV  <= ov_next;
                        acc <= '0;
                        cnt <= '0;
                    end else begin
                        acc <= sum_full;
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator (n=4, K=4, m=6): a cycle model predicts handshakes
// and queues each frame result, which is compared when the DUT presents it.
module tb_sum_accumulator;

    localparam int N = 4;
    localparam int K = 4;
    localparam int M = 6;

    typedef struct {
        logic signed [M-1:0] a;
        logic                ov;
    } res_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                clr;
    logic signed [N:0]   S;
    logic                S_valid;
    logic                S_ready;
    logic signed [M-1:0] A;
    logic                A_valid;
    logic                A_ready;
    logic                OV;

    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;
    res_t sb[$];

    int   m_acc = 0;
    int   m_cnt = 0;
    bit   m_hold = 1'b0;

    sum_accumulator #(.n(N), .K(K), .m(M)) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .S       (S),
        .S_valid (S_valid),
        .S_ready (S_ready),
        .A       (A),
        .A_valid (A_valid),
        .A_ready (A_ready),
        .OV      (OV)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, $signed(got), $signed(exp), $time);
        end
    endtask

    function automatic res_t narrow(input int f);
        res_t r;
        r.ov = (f > 31) || (f < -32);
`ifdef SUM_ACC_SAT_EN
        if (r.ov) r.a = (f > 0) ? 6'sb011111 : 6'sb100000;
        else      r.a = f[M-1:0];
`else
        r.a = f[M-1:0];
`endif
        return r;
    endfunction

    // Reference model, advanced on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        if (rst) begin
            m_hold = 1'b0;
            m_acc  = 0;
            m_cnt  = 0;
        end else if (!m_hold) begin
            if (clr) begin
                m_acc = 0;
                m_cnt = 0;
            end else if (S_valid) begin
                m_acc = m_acc + int'(S);
                m_cnt = m_cnt + 1;
                if (m_cnt == K) begin
                    sb.push_back(narrow(m_acc));
                    m_acc  = 0;
                    m_cnt  = 0;
                    m_hold = 1'b1;
                end
            end
        end else if (A_ready) begin
            m_hold = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("s_ready", S_ready, !m_hold);
            check("a_valid", A_valid, m_hold);
            if (m_hold && sb.size() > 0) begin
                check("a", A, sb[0].a);
                check("ov", OV, sb[0].ov);
                if (A_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input bit v, input int s, input bit ar, input bit c);
        S_valid = v;
        S       = s[N:0];
        A_ready = ar;
        clr     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic frame4(input int s0, input int s1, input int s2, input int s3);
        drive(1'b1, s0, 1'b1, 1'b0);
        drive(1'b1, s1, 1'b1, 1'b0);
        drive(1'b1, s2, 1'b1, 1'b0);
        drive(1'b1, s3, 1'b1, 1'b0);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        clr     = 1'b0;
        S       = 5'sd7;
        S_valid = 1'b1;
        A_ready = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_a", A, 0);
        check("rst_ov", OV, 0);
        rst = 1'b0;

        // Basic, positive and negative overflow frames
        frame4(1, 2, 3, 4);
        idle(2);
        frame4(15, 15, 15, 15);
        idle(2);
        frame4(-16, -16, -16, -16);
        idle(2);

        // Backpressure: the nines offered while holding must be ignored
        frame4(-3, 5, -7, 2);
        for (int i = 0; i < 5; i++) drive(1'b1, 9, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 9, 1'b1, 1'b0);
        idle(2);

        // clr drops the partial frame and the sample presented with it
        drive(1'b1, 8, 1'b1, 1'b0);
        drive(1'b1, 8, 1'b1, 1'b0);
        drive(1'b1, 8, 1'b1, 1'b1);
        frame4(1, 1, 1, 1);
        idle(2);

        // Reset mid-frame clears the held result and the partial sum
        drive(1'b1, 5, 1'b1, 1'b0);
        drive(1'b1, 5, 1'b1, 1'b0);
        drive(1'b1, 5, 1'b1, 1'b0);
        rst = 1'b1;
        drive(1'b0, 0, 1'b1, 1'b0);
        rst = 1'b0;
        check("midrst_a", A, 0);
        check("midrst_ov", OV, 0);
        frame4(2, 3, -1, 6);
        idle(2);

        // Random traffic with sporadic clr and backpressure
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), $signed($urandom_range(0, 31)) - 16,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end
        idle(4);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
